clock_time_ctrl: RTL and testbench

// - Mode/sequencing controller for the HH:MM clock datapath.
// - Generates the once-per-minute increment for the minute counter from a 1 Hz tick.
// - Forwards the minute counter's carry as an hour increment.
// - Arbitrates user time-setting (mode/inc buttons) against the running timebase.
// - Drives blink enables for the display.
// - Sits between the tick generator / buttons and the minute/hour counters.

---
 rtl/clock_ctrl_pkg.sv | 31 +++
 rtl/clock_btn_sync.sv | 31 +++
 rtl/clock_time_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_clock_time_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_ctrl_pkg.sv
// Shared types and constants for the HH:MM clock controller.
package clock_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      SET_MIN  = 2'd1,
      SET_HOUR = 2'd2
   } mode_t;

   localparam int unsigned SEC_PER_MIN   = 60;
   localparam int unsigned MIN_PER_HOUR  = 60;
   localparam int unsigned HOUR_PER_DAY  = 24;
   localparam int unsigned REPEAT_START  = 8;
   localparam int unsigned REPEAT_PERIOD = 2;
   localparam int unsigned BLINK_HALF    = 4;

   localparam int unsigned SEC_W   = $clog2(SEC_PER_MIN);
   localparam int unsigned BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   localparam int unsigned REP_MAX = (REPEAT_START > REPEAT_PERIOD) ? REPEAT_START : REPEAT_PERIOD;
   localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

   // Mode button sequence: RUN -> SET_MIN -> SET_HOUR -> RUN.
   function automatic mode_t next_mode(input mode_t m);
      case (m)
         RUN:     return SET_MIN;
         SET_MIN: return SET_HOUR;
         default: return RUN;
      endcase
   endfunction

endpackage

// File: rtl/clock_btn_sync.sv
// Raw button synchronizer: 2-flop sync, registered rising-edge pulse, synced level.
module clock_btn_sync (
   input  logic maqm_clock,
   input  logic maqm_reset,
   input  logic btn,
   output logic level,
   output logic rise
);

   logic meta;
   logic sync;
   logic sync_d;

   // Synchronize and detect the rising edge; pulse appears after the 3rd edge.
   always_ff @(posedge maqm_clock or negedge maqm_reset) begin
      if (!maqm_reset) begin
         meta   <= 1'b0;
         sync   <= 1'b0;
         sync_d <= 1'b0;
         rise   <= 1'b0;
      end else begin
         meta   <= btn;
         sync   <= meta;
         sync_d <= sync;
         rise   <= sync & ~sync_d;
      end
   end

   assign level = sync;

endmodule

// File: rtl/clock_time_ctrl.sv
// Mode/sequencing controller for the HH:MM clock datapath.
// Optional feature: define AUTO_REPEAT_EN for held-button auto-repeat in set modes.
module clock_time_ctrl
   import clock_ctrl_pkg::*;
(
   input  logic       maqm_clock,
   input  logic       maqm_reset,
   input  logic       tick_1hz,
   input  logic       tick_fast,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic       min_carry,
   output logic       ctl_min_en,
   output logic       ctl_min_inc,
   output logic       ctl_hour_inc,
   output logic       ctl_blink_min,
   output logic       ctl_blink_hour,
   output logic [1:0] ctl_mode
);

   mode_t              state, state_n;
   logic [SEC_W-1:0]   sec_cnt, sec_n;
   logic [BLINK_W-1:0] blink_cnt, blink_cnt_n;
   logic               blink_phase, blink_phase_n;
   logic               carry_q;
   logic               min_inc_n, hour_inc_n;
   logic               min_en_n, blink_min_n, blink_hour_n;
   logic               mode_level, mode_rise;
   logic               inc_level, inc_rise;
   logic               inc_req;
   logic               unused_lvl;

   clock_btn_sync u_sync_mode (
      .maqm_clock (maqm_clock),
      .maqm_reset (maqm_reset),
      .btn        (btn_mode),
      .level      (mode_level),
      .rise       (mode_rise)
   );

   clock_btn_sync u_sync_inc (
      .maqm_clock (maqm_clock),
      .maqm_reset (maqm_reset),
      .btn        (btn_inc),
      .level      (inc_level),
      .rise       (inc_rise)
   );

`ifdef AUTO_REPEAT_EN
   logic [REP_W-1:0] rep_cnt, rep_cnt_n;
   logic             rep_started, rep_started_n;
   logic             rep_fire;

   // Auto-repeat: first extra increment after REPEAT_START ticks, then every REPEAT_PERIOD.
   always_comb begin
      rep_cnt_n     = rep_cnt;
      rep_started_n = rep_started;
      rep_fire      = 1'b0;
      if (!inc_level || mode_rise || state == RUN) begin
         rep_cnt_n     = '0;
         rep_started_n = 1'b0;
      end else if (tick_fast) begin
         if (rep_started) begin
            if (rep_cnt == REP_W'(REPEAT_PERIOD - 1)) begin
               rep_cnt_n = '0;
               rep_fire  = 1'b1;
            end else begin
               rep_cnt_n = rep_cnt + 1'b1;
            end
         end else if (rep_cnt == REP_W'(REPEAT_START - 1)) begin
            rep_cnt_n     = '0;
            rep_started_n = 1'b1;
            rep_fire      = 1'b1;
         end else begin
            rep_cnt_n = rep_cnt + 1'b1;
         end
      end
   end

   // Repeat counter registers.
   always_ff @(posedge maqm_clock or negedge maqm_reset) begin
      if (!maqm_reset) begin
         rep_cnt     <= '0;
         rep_started <= 1'b0;
      end else begin
         rep_cnt     <= rep_cnt_n;
         rep_started <= rep_started_n;
      end
   end

   assign inc_req    = inc_rise | rep_fire;
   assign unused_lvl = mode_level;
`else
   assign inc_req    = inc_rise;
   assign unused_lvl = mode_level ^ inc_level;
`endif

   // Next-state, counters and next values of the registered outputs.
   always_comb begin
      state_n       = state;
      sec_n         = sec_cnt;
      blink_cnt_n   = blink_cnt;
      blink_phase_n = blink_phase;
      min_inc_n     = 1'b0;
      hour_inc_n    = 1'b0;

      if (tick_fast) begin
         if (blink_cnt == BLINK_W'(BLINK_HALF - 1)) begin
            blink_cnt_n   = '0;
            blink_phase_n = ~blink_phase;
         end else begin
            blink_cnt_n = blink_cnt + 1'b1;
         end
      end

      // A mode change restarts the blink with digits visible.
      if (mode_rise) begin
         state_n       = next_mode(state);
         blink_cnt_n   = '0;
         blink_phase_n = 1'b1;
      end

      case (state)
         RUN: begin
            // Only a fresh carry in RUN advances hours; set-mode carries are absorbed.
            hour_inc_n = min_carry & ~carry_q;
            if (mode_rise) begin
               sec_n = '0;
            end else if (tick_1hz) begin
               if (sec_cnt == SEC_W'(SEC_PER_MIN - 1)) begin
                  sec_n     = '0;
                  min_inc_n = 1'b1;
               end else begin
                  sec_n = sec_cnt + 1'b1;
               end
            end
         end
         SET_MIN: begin
            sec_n     = '0;
            min_inc_n = ~mode_rise & inc_req;
         end
         SET_HOUR: begin
            sec_n      = '0;
            hour_inc_n = ~mode_rise & inc_req;
         end
         default: begin
            state_n = RUN;
            sec_n   = '0;
         end
      endcase

      min_en_n     = (state_n != SET_HOUR);
      blink_min_n  = (state_n == SET_MIN)  ? blink_phase_n : 1'b1;
      blink_hour_n = (state_n == SET_HOUR) ? blink_phase_n : 1'b1;
   end

   // State, counters and registered outputs.
   always_ff @(posedge maqm_clock or negedge maqm_reset) begin
      if (!maqm_reset) begin
         state          <= RUN;
         sec_cnt        <= '0;
         blink_cnt      <= '0;
         blink_phase    <= 1'b1;
         carry_q        <= 1'b0;
         ctl_min_en     <= 1'b1;
         ctl_min_inc    <= 1'b0;
         ctl_hour_inc   <= 1'b0;
         ctl_blink_min  <= 1'b1;
         ctl_blink_hour <= 1'b1;
         ctl_mode       <= 2'(RUN);
      end else begin
         state          <= state_n;
         sec_cnt        <= sec_n;
         blink_cnt      <= blink_cnt_n;
         blink_phase    <= blink_phase_n;
         carry_q        <= min_carry;
         ctl_min_en     <= min_en_n;
         ctl_min_inc    <= min_inc_n;
         ctl_hour_inc   <= hour_inc_n;
         ctl_blink_min  <= blink_min_n;
         ctl_blink_hour <= blink_hour_n;
         ctl_mode       <= 2'(state_n);
      end
   end

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Self-checking bench for clock_time_ctrl: operation table plus directed corner sequences.
module tb_clock_time_ctrl;

   logic       maqm_clock;
   logic       maqm_reset;
   logic       tick_1hz;
   logic       tick_fast;
   logic       btn_mode;
   logic       btn_inc;
   logic       min_carry;
   logic       ctl_min_en;
   logic       ctl_min_inc;
   logic       ctl_hour_inc;
   logic       ctl_blink_min;
   logic       ctl_blink_hour;
   logic [1:0] ctl_mode;

   clock_time_ctrl dut (
      .maqm_clock     (maqm_clock),
      .maqm_reset     (maqm_reset),
      .tick_1hz       (tick_1hz),
      .tick_fast      (tick_fast),
      .btn_mode       (btn_mode),
      .btn_inc        (btn_inc),
      .min_carry      (min_carry),
      .ctl_min_en     (ctl_min_en),
      .ctl_min_inc    (ctl_min_inc),
      .ctl_hour_inc   (ctl_hour_inc),
      .ctl_blink_min  (ctl_blink_min),
      .ctl_blink_hour (ctl_blink_hour),
      .ctl_mode       (ctl_mode)
   );

   localparam int M_RUN = 0, M_SMIN = 1, M_SHOUR = 2;

`ifdef AUTO_REPEAT_EN
   localparam int EXP_REPEAT = 4;
`else
   localparam int EXP_REPEAT = 1;
`endif

   typedef enum int {OP_IDLE, OP_TICKS, OP_MODE, OP_INC, OP_BOTH, OP_CARRY_UP, OP_CARRY_DN} op_e;

   typedef struct {
      op_e op;
      int  n;
      int  exp_min;
      int  exp_hour;
      int  exp_mode;
      int  exp_en;
   } vec_t;

   localparam int NVEC = 14;
   vec_t vec [NVEC];

   int checks   = 0;
   int failures = 0;
   int min_cnt  = 0;
   int hour_cnt = 0;
   int base_min, base_hour;

   initial begin
      maqm_clock = 1'b0;
      forever #5 maqm_clock = ~maqm_clock;
   end

   // Count output pulses while out of reset.
   always @(negedge maqm_clock) begin
      if (maqm_reset) begin
         if (ctl_min_inc)  min_cnt  = min_cnt + 1;
         if (ctl_hour_inc) hour_cnt = hour_cnt + 1;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks = checks + 1;
      if (act !== exp) begin
         failures = failures + 1;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge maqm_clock);
   endtask

   task automatic press(input logic m, input logic i, input int n);
      repeat (n) begin
         btn_mode = m;
         btn_inc  = i;
         cyc(6);
         btn_mode = 1'b0;
         btn_inc  = 1'b0;
         cyc(6);
      end
   endtask

   task automatic ticks(input int n);
      repeat (n) begin
         tick_1hz = 1'b1;
         cyc(1);
         tick_1hz = 1'b0;
         cyc(1);
      end
   endtask

   task automatic fast(input int n);
      repeat (n) begin
         tick_fast = 1'b1;
         cyc(1);
         tick_fast = 1'b0;
         cyc(1);
      end
   endtask

   task automatic run_vec(input int idx);
      vec_t v;
      v = vec[idx];
      base_min  = min_cnt;
      base_hour = hour_cnt;
      case (v.op)
         OP_IDLE:     cyc(v.n);
         OP_TICKS:    ticks(v.n);
         OP_MODE:     press(1'b1, 1'b0, v.n);
         OP_INC:      press(1'b0, 1'b1, v.n);
         OP_BOTH:     press(1'b1, 1'b1, v.n);
         OP_CARRY_UP: begin min_carry = 1'b1; cyc(4); end
         OP_CARRY_DN: begin min_carry = 1'b0; cyc(4); end
         default:     cyc(1);
      endcase
      cyc(4);
      chk($sformatf("v%0d_min_inc", idx),  min_cnt - base_min,   v.exp_min);
      chk($sformatf("v%0d_hour_inc", idx), hour_cnt - base_hour, v.exp_hour);
      chk($sformatf("v%0d_mode", idx),     int'(ctl_mode),       v.exp_mode);
      chk($sformatf("v%0d_min_en", idx),   int'(ctl_min_en),     v.exp_en);
   endtask

   initial begin
      //         op           n   min hour mode     en
      vec[0]  = '{OP_IDLE,     20, 0,  0,   M_RUN,   1};
      vec[1]  = '{OP_CARRY_DN, 1,  0,  0,   M_RUN,   1};
      vec[2]  = '{OP_INC,      1,  0,  0,   M_RUN,   1};
      vec[3]  = '{OP_MODE,     1,  0,  0,   M_SMIN,  1};
      vec[4]  = '{OP_INC,      3,  3,  0,   M_SMIN,  1};
      vec[5]  = '{OP_CARRY_UP, 1,  0,  0,   M_SMIN,  1};
      vec[6]  = '{OP_CARRY_DN, 1,  0,  0,   M_SMIN,  1};
      vec[7]  = '{OP_MODE,     1,  0,  0,   M_SHOUR, 0};
      vec[8]  = '{OP_INC,      1,  0,  1,   M_SHOUR, 0};
      vec[9]  = '{OP_TICKS,    30, 0,  0,   M_SHOUR, 0};
      vec[10] = '{OP_BOTH,     1,  0,  0,   M_RUN,   1};
      vec[11] = '{OP_TICKS,    59, 0,  0,   M_RUN,   1};
      vec[12] = '{OP_TICKS,    1,  1,  0,   M_RUN,   1};
      vec[13] = '{OP_BOTH,     1,  0,  0,   M_SMIN,  1};

      maqm_reset = 1'b0;
      tick_1hz   = 1'b0;
      tick_fast  = 1'b0;
      btn_mode   = 1'b0;
      btn_inc    = 1'b0;
      min_carry  = 1'b0;
      cyc(3);

      chk("rst_mode",       int'(ctl_mode),       M_RUN);
      chk("rst_min_en",     int'(ctl_min_en),     1);
      chk("rst_blink_min",  int'(ctl_blink_min),  1);
      chk("rst_blink_hour", int'(ctl_blink_hour), 1);
      chk("rst_min_inc",    int'(ctl_min_inc),    0);
      chk("rst_hour_inc",   int'(ctl_hour_inc),   0);
      maqm_reset = 1'b1;
      cyc(2);

      // 60 seconds: one minute pulse, exactly one cycle after the 60th tick.
      base_min = min_cnt;
      ticks(59);
      chk("sec59_no_inc", min_cnt - base_min, 0);
      tick_1hz = 1'b1;
      cyc(1);
      tick_1hz = 1'b0;
      chk("sec60_inc_next", int'(ctl_min_inc), 1);
      cyc(1);
      chk("sec60_inc_1cyc", int'(ctl_min_inc), 0);
      cyc(2);
      chk("sec60_total", min_cnt - base_min, 1);

      // Carry rise in RUN: hour pulse the next cycle only.
      base_hour = hour_cnt;
      min_carry = 1'b1;
      cyc(1);
      chk("carry_hour_next", int'(ctl_hour_inc), 1);
      cyc(1);
      chk("carry_hour_1cyc", int'(ctl_hour_inc), 0);
      chk("carry_total", hour_cnt - base_hour, 1);

      for (int i = 0; i < NVEC; i++) run_vec(i);

      // Blink in SET_MIN: visible on entry, toggles every 4 fast ticks.
      chk("blink_entry_min",  int'(ctl_blink_min),  1);
      chk("blink_entry_hour", int'(ctl_blink_hour), 1);
      fast(3);
      chk("blink_3_min", int'(ctl_blink_min), 1);
      fast(1);
      chk("blink_4_min",  int'(ctl_blink_min),  0);
      chk("blink_4_hour", int'(ctl_blink_hour), 1);
      fast(4);
      chk("blink_8_min", int'(ctl_blink_min), 1);

      // Inc press latency: pulse visible after the 4th edge, one cycle wide.
      btn_inc = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         cyc(1);
         chk($sformatf("inc_lat_c%0d", k), int'(ctl_min_inc), (k == 4) ? 1 : 0);
      end
      cyc(3);
      btn_inc = 1'b0;
      cyc(6);

      // Held inc across 12 fast ticks.
      base_min = min_cnt;
      btn_inc  = 1'b1;
      cyc(5);
      fast(12);
      cyc(4);
      chk("repeat_count", min_cnt - base_min, EXP_REPEAT);
      chk("blink_pre_rst", int'(ctl_blink_min), 0);
      btn_inc = 1'b0;
      cyc(6);

      // Reset asserted while an increment pulse is high.
      btn_inc = 1'b1;
      cyc(4);
      chk("pulse_pre_rst", int'(ctl_min_inc), 1);
      #2 maqm_reset = 1'b0;
      #1;
      chk("arst_min_inc",    int'(ctl_min_inc),    0);
      chk("arst_hour_inc",   int'(ctl_hour_inc),   0);
      chk("arst_mode",       int'(ctl_mode),       M_RUN);
      chk("arst_min_en",     int'(ctl_min_en),     1);
      chk("arst_blink_min",  int'(ctl_blink_min),  1);
      chk("arst_blink_hour", int'(ctl_blink_hour), 1);
      cyc(2);
      base_min   = min_cnt;
      maqm_reset = 1'b1;
      cyc(8);
      btn_inc = 1'b0;
      cyc(6);
      chk("post_rst_mode",   int'(ctl_mode),    M_RUN);
      chk("post_rst_no_inc", min_cnt - base_min, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
